// File: rtl/seg_display_arbiter.sv
// Arbitrates the 4-digit seven-segment scanner among three requesters with fixed priority,
// a minimum on-screen hold window with strict-priority preemption, and a free-running scan tick.
module seg_display_arbiter #(
    parameter int unsigned HOLD_CYC = 50000,
    parameter int unsigned SCAN_DIV = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic [2:0]  grant,
    output logic [1:0]  owner,
    output logic [15:0] disp_val,
    output logic        disp_load,
    output logic        hold_busy,
    output logic        scan_tick,
    output logic        blank
);

    localparam int unsigned HW = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
    localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic [SW-1:0] scan_cnt;

    logic [2:0]    grant_n;
    logic [1:0]    owner_n;
    logic [15:0]   disp_val_n;
    logic          disp_load_n;
    logic          blank_n;

    logic [1:0]    winner;
    logic [15:0]   winner_data;

    // Fixed priority: lowest index wins.
    always_comb begin
        if (req[0])      winner = 2'd0;
        else if (req[1]) winner = 2'd1;
        else             winner = 2'd2;
    end

    always_comb begin
        case (winner)
            2'd0:    winner_data = data0;
            2'd1:    winner_data = data1;
            default: winner_data = data2;
        endcase
    end

    always_comb begin
        state_n     = state;
        hold_cnt_n  = hold_cnt;
        grant_n     = '0;
        disp_load_n = 1'b0;
        disp_val_n  = disp_val;
        owner_n     = owner;
        blank_n     = blank;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_n     = LOAD;
                    grant_n     = 3'b001 << winner;
                    disp_load_n = 1'b1;
                    disp_val_n  = winner_data;
                    owner_n     = winner;
                    blank_n     = 1'b0;
                end
            end
            LOAD: begin
                state_n    = HOLD;
                hold_cnt_n = HW'(HOLD_CYC - 1);
            end
            HOLD: begin
                // Only a strictly higher-priority request may cut the window short.
                if (|req && (winner < owner)) begin
                    state_n     = LOAD;
                    grant_n     = 3'b001 << winner;
                    disp_load_n = 1'b1;
                    disp_val_n  = winner_data;
                    owner_n     = winner;
                    blank_n     = 1'b0;
                end else if (hold_cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    hold_cnt_n = hold_cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            grant     <= '0;
            disp_load <= 1'b0;
            disp_val  <= '0;
            owner     <= 2'd3;
            blank     <= 1'b1;
            hold_busy <= 1'b0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_cnt_n;
            grant     <= grant_n;
            disp_load <= disp_load_n;
            disp_val  <= disp_val_n;
            owner     <= owner_n;
            blank     <= blank_n;
            hold_busy <= (state_n == HOLD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign scan_tick = (scan_cnt == SW'(SCAN_DIV - 1));

endmodule
